// File: rtl/debug_pkg.sv
// debug_pkg -- shared definitions for the debug command sequencer.
//   state_e    : sequencer state encoding (also exported on current_state)
//   CMD_*      : ASCII command bytes received over the UART
//   RSN_*      : stop_reason codes reported at the end of every command
//   takes_arg(): true for commands that are followed by argument bytes
package debug_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_WAIT_CMD = 3'd1,
        ST_GET_ARG  = 3'd2,
        ST_STEPPING = 3'd3,
        ST_RUNNING  = 3'd4,
        ST_SW_RESET = 3'd5,
        ST_REPORT   = 3'd6
    } state_e;

    localparam logic [7:0] CMD_STEP1 = 8'h31;
    localparam logic [7:0] CMD_RUN   = 8'h32;
    localparam logic [7:0] CMD_SWRST = 8'h33;
    localparam logic [7:0] CMD_STEPN = 8'h34;
    localparam logic [7:0] CMD_SETBP = 8'h35;
    localparam logic [7:0] CMD_CLRBP = 8'h36;

    localparam logic [2:0] RSN_DONE     = 3'd0;
    localparam logic [2:0] RSN_FINISHED = 3'd1;
    localparam logic [2:0] RSN_BREAK    = 3'd2;
    localparam logic [2:0] RSN_TIMEOUT  = 3'd3;
    localparam logic [2:0] RSN_SWRST    = 3'd4;
    localparam logic [2:0] RSN_UNKNOWN  = 3'd5;

    function automatic logic takes_arg(input logic [7:0] cmd);
        return (cmd == CMD_STEPN) || (cmd == CMD_SETBP);
    endfunction

endpackage

// File: rtl/debug_arg_shift.sv
// debug_arg_shift -- assembles a BYTES-wide argument received LSB first.
//   clock, reset : clock and synchronous active-high reset
//   load_i       : clear the register and restart the byte count
//   shift_i      : accept byte_i (ignored once done_o is high)
//   byte_i       : incoming argument byte
//   value_o      : assembled argument, first byte in the least significant lane
//   done_o       : all BYTES bytes have been received
module debug_arg_shift #(
    parameter int BYTES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [7:0]         byte_i,
    output logic [BYTES*8-1:0] value_o,
    output logic               done_o
);

    localparam int CNT_W = $clog2(BYTES + 1);

    logic [BYTES-1:0][7:0] lane_q;
    logic [BYTES-1:0][7:0] lane_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  take;

    assign take = shift_i && !done_o;

    // Bytes enter at the top lane and move down, so after BYTES shifts the
    // first byte received has reached lane 0 (least significant).
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            if (gi == BYTES - 1) begin : g_top
                assign lane_d[gi] = take ? byte_i : lane_q[gi];
            end else begin : g_mid
                assign lane_d[gi] = take ? lane_q[gi+1] : lane_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset || load_i) begin
            lane_q <= '0;
            cnt_q  <= '0;
        end else begin
            lane_q <= lane_d;
            if (take) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign value_o = lane_q;
    assign done_o  = (cnt_q == CNT_W'(BYTES));

endmodule

// File: rtl/debug_cmd_seq.sv
// debug_cmd_seq -- UART-driven debug controller for a pipelined CPU.
// Decodes single-byte commands (step, step N, run, software reset, set/clear
// breakpoint), drives the pipeline clock enable / reset and reports a stop
// reason to the transmitter after every command.
//   clock, reset      : clock and synchronous active-high reset
//   r_data, rx_ready  : received UART byte and its availability flag
//   rd_uart           : one-cycle pulse consuming the current byte
//   dataSent          : transmitter finished sending the report
//   sendSignal        : report request, held until dataSent
//   program_finished  : pipeline retired its final instruction
//   pc                : pipeline fetch PC used for the breakpoint compare
//   pipeline_clk_en   : pipeline clock enable
//   pipelineReset     : pipeline reset, active-high
//   stop_reason       : code of the last completed command
//   current_state     : state encoding for debug visibility
module debug_cmd_seq
    import debug_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int STEP_W    = 8,
    parameter int RUN_MAX   = 65535,
    parameter int SWRST_CYC = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0]      r_data,
    input  logic            rx_ready,
    output logic            rd_uart,
    input  logic            dataSent,
    output logic            sendSignal,
    input  logic            program_finished,
    input  logic [PC_W-1:0] pc,
    output logic            pipeline_clk_en,
    output logic            pipelineReset,
    output logic [2:0]      stop_reason,
    output logic [2:0]      current_state
);

    localparam int CYC_MAX = (RUN_MAX > SWRST_CYC) ? RUN_MAX : SWRST_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic                first_q, first_d;
    logic                rd_q, rd_d;
    logic [2:0]          reason_q, reason_d;
    logic                bp_valid_q, bp_valid_d;
    logic [PC_W-1:0]     bp_addr_q, bp_addr_d;
    logic                is_step_q, is_step_d;

    logic                byte_avail;
    logic                arg_load;
    logic                arg_shift;
    logic                arg_done;
    logic                step_done;
    logic                bp_done;
    logic                bp_hit;
    logic [STEP_W-1:0]   step_val;
    logic [PC_W-1:0]     bp_val;

    debug_arg_shift #(.BYTES(STEP_W / 8)) u_step_arg (
        .clock   (clock),
        .reset   (reset),
        .load_i  (arg_load),
        .shift_i (arg_shift && is_step_q),
        .byte_i  (r_data),
        .value_o (step_val),
        .done_o  (step_done)
    );

    debug_arg_shift #(.BYTES(PC_W / 8)) u_bp_arg (
        .clock   (clock),
        .reset   (reset),
        .load_i  (arg_load),
        .shift_i (arg_shift && !is_step_q),
        .byte_i  (r_data),
        .value_o (bp_val),
        .done_o  (bp_done)
    );

    // A byte is still flagged during its own rd_uart pulse; skip that cycle.
    assign byte_avail = rx_ready && !rd_q;
    assign arg_done   = is_step_q ? step_done : bp_done;
    // No compare on the first cycle, so a resume from a breakpoint advances.
    assign bp_hit     = bp_valid_q && (pc == bp_addr_q) && !first_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cyc_d           = cyc_q;
        first_d         = 1'b0;
        rd_d            = 1'b0;
        reason_d        = reason_q;
        bp_valid_d      = bp_valid_q;
        bp_addr_d       = bp_addr_q;
        is_step_d       = is_step_q;
        arg_load        = 1'b0;
        arg_shift       = 1'b0;
        pipeline_clk_en = 1'b0;
        pipelineReset   = 1'b0;
        sendSignal      = 1'b0;

        case (state_q)
            ST_INIT: begin
                pipelineReset   = 1'b1;
                pipeline_clk_en = 1'b1;
                state_d         = ST_WAIT_CMD;
            end
            ST_WAIT_CMD: begin
                if (byte_avail) begin
                    rd_d = 1'b1;
                    if (takes_arg(r_data)) begin
                        is_step_d = (r_data == CMD_STEPN);
                        arg_load  = 1'b1;
                        state_d   = ST_GET_ARG;
                    end else begin
                        case (r_data)
                            CMD_STEP1: begin
                                cnt_d   = STEP_W'(1);
                                first_d = 1'b1;
                                state_d = ST_STEPPING;
                            end
                            CMD_RUN: begin
                                cyc_d   = '0;
                                first_d = 1'b1;
                                state_d = ST_RUNNING;
                            end
                            CMD_SWRST: begin
                                cyc_d   = '0;
                                state_d = ST_SW_RESET;
                            end
                            CMD_CLRBP: begin
                                bp_valid_d = 1'b0;
                                reason_d   = RSN_DONE;
                                state_d    = ST_REPORT;
                            end
                            default: begin
                                reason_d = RSN_UNKNOWN;
                                state_d  = ST_REPORT;
                            end
                        endcase
                    end
                end
            end
            ST_GET_ARG: begin
                if (arg_done) begin
                    if (is_step_q) begin
                        cnt_d   = step_val;
                        first_d = 1'b1;
                        state_d = ST_STEPPING;
                    end else begin
                        bp_addr_d  = bp_val;
                        bp_valid_d = 1'b1;
                        reason_d   = RSN_DONE;
                        state_d    = ST_REPORT;
                    end
                end else if (byte_avail) begin
                    rd_d      = 1'b1;
                    arg_shift = 1'b1;
                end
            end
            ST_STEPPING: begin
                if (cnt_q == '0) begin
                    reason_d = RSN_DONE;
                    state_d  = ST_REPORT;
                end else if (program_finished) begin
                    reason_d = RSN_FINISHED;
                    state_d  = ST_REPORT;
                end else if (bp_hit) begin
                    reason_d = RSN_BREAK;
                    state_d  = ST_REPORT;
                end else begin
                    pipeline_clk_en = 1'b1;
                    cnt_d           = cnt_q - 1'b1;
                    if (cnt_q == STEP_W'(1)) begin
                        reason_d = RSN_DONE;
                        state_d  = ST_REPORT;
                    end
                end
            end
            ST_RUNNING: begin
                if (program_finished) begin
                    reason_d = RSN_FINISHED;
                    state_d  = ST_REPORT;
                end else if (bp_hit) begin
                    reason_d = RSN_BREAK;
                    state_d  = ST_REPORT;
                end else begin
                    pipeline_clk_en = 1'b1;
                    cyc_d           = cyc_q + 1'b1;
                    if (cyc_q == CYC_W'(RUN_MAX - 1)) begin
                        reason_d = RSN_TIMEOUT;
                        state_d  = ST_REPORT;
                    end
                end
            end
            ST_SW_RESET: begin
                pipelineReset   = 1'b1;
                pipeline_clk_en = 1'b1;
                cyc_d           = cyc_q + 1'b1;
                if (cyc_q == CYC_W'(SWRST_CYC - 1)) begin
                    reason_d = RSN_SWRST;
                    state_d  = ST_REPORT;
                end
            end
            ST_REPORT: begin
                sendSignal = 1'b1;
                if (dataSent) begin
                    state_d = ST_WAIT_CMD;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Reset overrides everything: pipeline held in reset, nothing enabled.
        if (reset) begin
            pipeline_clk_en = 1'b0;
            pipelineReset   = 1'b1;
            sendSignal      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            cyc_q      <= '0;
            first_q    <= 1'b0;
            rd_q       <= 1'b0;
            reason_q   <= RSN_DONE;
            bp_valid_q <= 1'b0;
            bp_addr_q  <= '0;
            is_step_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            first_q    <= first_d;
            rd_q       <= rd_d;
            reason_q   <= reason_d;
            bp_valid_q <= bp_valid_d;
            bp_addr_q  <= bp_addr_d;
            is_step_q  <= is_step_d;
        end
    end

    assign rd_uart       = rd_q;
    assign stop_reason   = reason_q;
    assign current_state = state_q;

endmodule

// File: tb/tb_debug_cmd_seq.sv
module tb_debug_cmd_seq;
    import debug_pkg::*;

    localparam int PC_W      = 32;
    localparam int STEP_W    = 8;
    localparam int RUN_MAX   = 16;
    localparam int SWRST_CYC = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  r_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic        rd_uart;
    logic        dataSent = 1'b0;
    logic        sendSignal;
    logic        program_finished = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        pipeline_clk_en;
    logic        pipelineReset;
    logic [2:0]  stop_reason;
    logic [2:0]  current_state;

    always #5 clock = ~clock;

    debug_cmd_seq #(
        .PC_W      (PC_W),
        .STEP_W    (STEP_W),
        .RUN_MAX   (RUN_MAX),
        .SWRST_CYC (SWRST_CYC)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .r_data           (r_data),
        .rx_ready         (rx_ready),
        .rd_uart          (rd_uart),
        .dataSent         (dataSent),
        .sendSignal       (sendSignal),
        .program_finished (program_finished),
        .pc               (pc),
        .pipeline_clk_en  (pipeline_clk_en),
        .pipelineReset    (pipelineReset),
        .stop_reason      (stop_reason),
        .current_state    (current_state)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int rsn;
        int en;
        int rd;
        int prst;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state: what the pipeline PC and breakpoint should be.
    bit [31:0] m_pc = 32'h0;
    bit [31:0] m_bp = 32'h0;
    bit        m_bpv = 1'b0;
    bit [31:0] fin_pc = 32'hFFFF_FFFF;
    bit        init_pending = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pipeline stand-in: PC advances by 4 on every enabled cycle, cleared by reset.
    initial begin
        bit en_s, rs_s;
        forever begin
            @(negedge clock);
            en_s = pipeline_clk_en;
            rs_s = pipelineReset;
            tick();
            if (rs_s) pc = 32'h0;
            else if (en_s) pc = pc + 32'd4;
            program_finished = (pc >= fin_pc);
        end
    end

    // Transmitter stand-in: acknowledges a report after a random delay.
    initial begin
        forever begin
            tick();
            if (dataSent) dataSent = 1'b0;
            else if (sendSignal && $urandom_range(0, 2) == 0) dataSent = 1'b1;
        end
    end

    // Monitor: counts activity per command and checks it when the report appears.
    initial begin
        int   c_en, c_rd, c_prst, rep_rsn;
        bit   in_rep;
        exp_t e;
        c_en = 0; c_rd = 0; c_prst = 0; rep_rsn = 0; in_rep = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                c_en = 0; c_rd = 0; c_prst = 0; in_rep = 1'b0;
            end else begin
                c_en   += int'(pipeline_clk_en);
                c_rd   += int'(rd_uart);
                c_prst += int'(pipelineReset);
                if (sendSignal && !in_rep) begin
                    in_rep = 1'b1;
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_report: stop_reason %0d with no command pending", stop_reason);
                        rep_rsn = int'(stop_reason);
                    end else begin
                        e = sb_q.pop_front();
                        check("stop_reason", int'(stop_reason), e.rsn);
                        check("clk_en_cycles", c_en, e.en);
                        check("rd_pulses", c_rd, e.rd);
                        check("pipe_reset_cycles", c_prst, e.prst);
                        $display("report: reason=%0d en=%0d rd=%0d prst=%0d", stop_reason, c_en, c_rd, c_prst);
                        rep_rsn = e.rsn;
                    end
                    c_en = 0; c_rd = 0; c_prst = 0;
                end else if (sendSignal && in_rep) begin
                    check("stop_reason_stable", int'(stop_reason), rep_rsn);
                end else if (!sendSignal && in_rep) begin
                    in_rep = 1'b0;
                    check("clk_en_in_report", c_en, 0);
                    c_en = 0; c_rd = 0; c_prst = 0;
                end
            end
        end
    end

    // Behavioural model of a step/run: at most 'limit' enabled cycles,
    // stopping early on program finish or on a breakpoint (not on the first cycle).
    task automatic model_exec(input int limit, input int done_rsn, output int n, output int r);
        n = 0;
        r = done_rsn;
        for (int i = 0; i < limit; i++) begin
            if (m_pc >= fin_pc) begin
                r = 1;
                return;
            end
            if (i > 0 && m_bpv && m_pc == m_bp) begin
                r = 2;
                return;
            end
            m_pc = m_pc + 32'd4;
            n++;
        end
    endtask

    task automatic push_exp(input int rsn, input int en, input int rd, input int prst);
        exp_t e;
        e.rsn = rsn; e.en = en; e.rd = rd; e.prst = prst;
        if (init_pending) begin
            e.en++;
            e.prst++;
            init_pending = 1'b0;
        end
        sb_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) tick();
        tick();
        r_data   = b;
        rx_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (rd_uart) begin
                rx_ready = 1'b0;
                return;
            end
        end
        rx_ready = 1'b0;
        total++;
        bad++;
        $display("FAIL rd_uart_timeout: byte %02h got no rd_uart, required one pulse", b);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            tick();
            if (sb_q.size() == 0 && !sendSignal) return;
        end
        total++;
        bad++;
        $display("FAIL idle_timeout: pending=%0d sendSignal=%0b, required report completed", sb_q.size(), sendSignal);
        sb_q.delete();
    endtask

    task automatic do_reset();
        tick();
        reset    = 1'b1;
        rx_ready = 1'b0;
        tick();
        tick();
        @(negedge clock);
        check("rst_rd_uart", int'(rd_uart), 0);
        check("rst_sendSignal", int'(sendSignal), 0);
        check("rst_clk_en", int'(pipeline_clk_en), 0);
        check("rst_pipelineReset", int'(pipelineReset), 1);
        check("rst_stop_reason", int'(stop_reason), 0);
        check("rst_state", int'(current_state), int'(ST_INIT));
        tick();
        reset        = 1'b0;
        m_pc         = 32'h0;
        m_bpv        = 1'b0;
        init_pending = 1'b1;
        sb_q.delete();
        $display("reset applied");
    endtask

    task automatic set_pc(input bit [31:0] v);
        tick();
        pc               = v;
        m_pc             = v;
        program_finished = (pc >= fin_pc);
    endtask

    task automatic set_fin(input bit [31:0] v);
        tick();
        fin_pc           = v;
        program_finished = (pc >= fin_pc);
    endtask

    task automatic do_step1();
        int n, r;
        model_exec(1, 0, n, r);
        push_exp(r, n, 1, 0);
        send_byte(CMD_STEP1);
        wait_idle();
    endtask

    task automatic do_stepn(input int k);
        int n, r;
        model_exec(k, 0, n, r);
        push_exp(r, n, 2, 0);
        send_byte(CMD_STEPN);
        send_byte(8'(k));
        wait_idle();
    endtask

    task automatic do_run();
        int n, r;
        model_exec(RUN_MAX, 3, n, r);
        push_exp(r, n, 1, 0);
        send_byte(CMD_RUN);
        wait_idle();
    endtask

    task automatic do_swrst();
        m_pc = 32'h0;
        push_exp(4, SWRST_CYC, 1, SWRST_CYC);
        send_byte(CMD_SWRST);
        wait_idle();
    endtask

    task automatic do_setbp(input bit [31:0] a);
        m_bp  = a;
        m_bpv = 1'b1;
        push_exp(0, 0, 1 + PC_W / 8, 0);
        send_byte(CMD_SETBP);
        for (int i = 0; i < PC_W / 8; i++) send_byte(a[8*i +: 8]);
        wait_idle();
    endtask

    task automatic do_clrbp();
        m_bpv = 1'b0;
        push_exp(0, 0, 1, 0);
        send_byte(CMD_CLRBP);
        wait_idle();
    endtask

    task automatic do_unknown(input logic [7:0] b);
        push_exp(5, 0, 1, 0);
        send_byte(b);
        wait_idle();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        do_reset();
        do_step1();
        do_stepn(5);
        do_stepn(0);
        // Breakpoint at 0x40000000 sent LSB first, then resume past it.
        set_pc(32'h3FFF_FFF0);
        do_setbp(32'h4000_0000);
        do_run();
        do_run();
        // Program finishes after 10 enabled cycles.
        set_fin(m_pc + 32'd40);
        do_run();
        set_fin(32'hFFFF_FFFF);
        do_run();
        do_swrst();
        do_unknown(8'h7A);
        do_clrbp();
        // Reset while waiting for a step-N argument; breakpoint must be gone.
        do_setbp(32'h20);
        send_byte(CMD_STEPN);
        repeat (2) tick();
        do_reset();
        do_run();
        // Reset in the middle of a run.
        do_setbp(32'h200);
        send_byte(CMD_RUN);
        repeat (5) tick();
        do_reset();
        do_step1();
        do_stepn(3);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) set_fin(m_pc + 32'(4 * $urandom_range(0, 20)));
            else set_fin(32'hFFFF_FFFF);
            case ($urandom_range(0, 6))
                0: do_step1();
                1: do_stepn($urandom_range(0, 12));
                2: do_run();
                3: do_swrst();
                4: do_setbp(m_pc + 32'(4 * $urandom_range(0, 20)));
                5: do_clrbp();
                default: begin
                    do b = $urandom_range(0, 255);
                    while (b >= 8'h31 && b <= 8'h36);
                    do_unknown(8'(b));
                end
            endcase
        end

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
